register_arbiter: RTL
=====================

REGISTER_ARBITER -- requirements
Module: register_arbiter

Interface
REQ-001 The block SHALL have parameter: NREQ, 3, number of writeback requesters (2..4).
REQ-002 The block SHALL have port: clk  in  1  rising-edge clock.
REQ-003 The block SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port: req_valid  in  NREQ  per-requester writeback valid.
REQ-005 The block SHALL have port: req_addr  in  NREQ*5  packed destination indices, requester i at [5i+4:5i].
REQ-006 The block SHALL have port: req_data  in  NREQ*32  packed write data, requester i at [32i+31:32i].
REQ-007 The block SHALL have port: req_ready  out  NREQ  one-hot grant, combinational.
REQ-008 The block SHALL have port: iss_valid  in  1  issue of an instruction writing iss_addr.
REQ-009 The block SHALL have port: iss_addr  in  5  destination of issuing instruction.
REQ-010 The block SHALL have port: iss_ready  out  1  issue acceptable, combinational.
REQ-011 The block SHALL have port: raddr1, raddr2  in  5 each  read indices to check.
REQ-012 The block SHALL have port: haz1, haz2  out  1 each  read index has pending write.
REQ-013 The block SHALL have port: flush  in  1  synchronous pipeline flush.
REQ-014 The block SHALL have port: wren, waddr, wdata  out  1/5/32  registered register-file write port.

Function
REQ-015 At most one req_ready bit SHALL be high per cycle; requester i transfers when req_valid[i] & req_ready[i].
REQ-016 A requester with valid high and ready low SHALL hold addr/data stable; the arbiter SHALL NOT depend on withdrawal.
REQ-017 Transfer at edge N SHALL drive wren=1, waddr, wdata during cycle N+1 (latency 1); no transfer -> wren=0, waddr/wdata hold.
REQ-018 A transfer with addr 0 SHALL be accepted but SHALL produce wren=0.
REQ-019 Scoreboard busy[31:1]: accepted issue (iss_valid & iss_ready, iss_addr!=0) SHALL set busy[iss_addr] at the edge.
REQ-020 Edge ending a cycle with wren=1 SHALL clear busy[waddr]; same-edge set and clear of one index -> set wins.
REQ-021 iss_ready SHALL equal ~busy[iss_addr] (always 1 for index 0); WAW issue is blocked.
REQ-022 haz1/haz2 SHALL equal busy[raddr1]/busy[raddr2], 0 for index 0; hazard persists during the wren cycle, clears after.
REQ-023 flush=1 SHALL force req_ready=0 and iss_ready=0 that cycle, clear all busy bits and drive wren=0 next cycle.
REQ-024 flush SHALL take precedence over any same-cycle transfer, issue or clear.

Reset
REQ-025 rst low SHALL immediately force wren=0, waddr=0, wdata=0, busy=0, rr pointer=NREQ-1, independent of clk.
REQ-026 Reset deassertion mid-operation SHALL discard all in-flight writebacks; first grant after reset goes to lowest valid index.

Configuration
REQ-027 With REGISTER_ARBITER_RR_EN defined, grant SHALL be round-robin: search starts at pointer+1 mod NREQ; pointer updates to granted index only on transfer.
REQ-028 Without REGISTER_ARBITER_RR_EN, grant SHALL be fixed priority, lowest index wins, no pointer state.

Verification
REQ-029 Reset: rst low mid-transfer -> wren=0, haz1=haz2=0 without clock edge; after release req0 and req2 valid -> req_ready=001.
REQ-030 Issue x5, then req1 writes x5=0xDEADBEEF -> haz1 (raddr1=5) high until edge after wren cycle; wren=1, waddr=5, wdata=0xDEADBEEF one cycle after transfer.
REQ-031 All three valid continuously, RR_EN defined -> grants 0,1,2,0,1,2; undefined -> req0 granted every cycle.
REQ-032 busy[7]=1, iss x7 while wren clears x7 same cycle -> iss_ready=0 that cycle, 1 next cycle; issue x7 on edge clearing x7 (ready from other path) -> busy[7] stays 1.
REQ-033 req0 write to x0 data 0x12345678 -> req_ready[0]=1, wren stays 0.
REQ-034 flush with busy x3,x9 and req1 valid -> req_ready=0, busy all clear, wren=0 next cycle, haz on x3 low.

Source files
------------

// File: rtl/register_arbiter.sv
// Writeback arbiter with a register scoreboard: grants one writeback per cycle onto a
// registered register-file write port and tracks pending destinations. Define
// REGISTER_ARBITER_RR_EN for round-robin grant; otherwise the lowest index wins.
module register_arbiter #(
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_addr,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_addr,
  output logic                 iss_ready,
  input  logic [4:0]           raddr1,
  input  logic [4:0]           raddr2,
  output logic                 haz1,
  output logic                 haz2,
  input  logic                 flush,
  output logic                 wren,
  output logic [4:0]           waddr,
  output logic [31:0]          wdata
);

  logic [NREQ-1:0] grant;
  logic            found;
  logic            xfer;
  logic [4:0]      sel_addr;
  logic [31:0]     sel_data;
  logic [31:0]     busy;
  logic [31:0]     busy_next;

`ifdef REGISTER_ARBITER_RR_EN
  logic [1:0]      ptr;
  logic [1:0]      gidx;

  // Search begins one past the last granted requester and wraps around.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        grant[(int'(ptr) + k) % NREQ] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gidx = 2'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 2'(NREQ - 1);
    end else if (xfer) begin
      ptr <= gidx;
    end
  end
`else
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

  assign req_ready = flush ? '0 : grant;
  assign xfer      = |req_ready;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[5*i +: 5];
        sel_data = req_data[32*i +: 32];
      end
    end
  end

  // Bit 0 is never set, so x0 reads as ready and hazard-free without special casing.
  assign iss_ready = !flush && !busy[iss_addr];
  assign haz1      = busy[raddr1];
  assign haz2      = busy[raddr2];

  // Clear from the writeback first so a same-edge issue to that index wins.
  always_comb begin
    busy_next = busy;
    if (wren) busy_next[waddr] = 1'b0;
    if (iss_valid && iss_ready && iss_addr != 5'd0) busy_next[iss_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy  <= '0;
      wren  <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (flush) begin
      busy  <= '0;
      wren  <= 1'b0;
    end else begin
      busy <= busy_next;
      if (xfer) begin
        wren  <= (sel_addr != 5'd0);
        waddr <= sel_addr;
        wdata <= sel_data;
      end else begin
        wren  <= 1'b0;
      end
    end
  end

endmodule
